scope_wavegen_dac_tx: RTL and testbench

- On-chip test-signal generator for the scope, driving an external 8-bit SPI DAC (MCP4801-style, 16-bit write frame).
- Its analog output is looped back into the scope's acquisition input during bring-up and self-test.
- A phase accumulator plus shape logic produces one 8-bit sample per SPI frame.
- An SPI mode-0 transmitter shifts each frame out MSB first, back to back while enabled.

---
 rtl/scope_wavegen_dac_tx_if.sv | 22 ++
 rtl/scope_wavegen_dac_tx.sv | 119 +++++++++++
 tb/tb_scope_wavegen_dac_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/scope_wavegen_dac_tx_if.sv
// Control and DAC-pin bundle for the scope test-signal generator.
// The generator drives the slave side; the controller/pins drive the master side.
interface scope_wavegen_dac_tx_if;
    logic       ena;
    logic [1:0] shape;
    logic [7:0] freq_step;
    logic [7:0] sample;
    logic       frame_done;
    logic       dac_cs_n;
    logic       dac_sclk;
    logic       dac_mosi;

    modport master (
        output ena, shape, freq_step,
        input  sample, frame_done, dac_cs_n, dac_sclk, dac_mosi
    );

    modport slave (
        input  ena, shape, freq_step,
        output sample, frame_done, dac_cs_n, dac_sclk, dac_mosi
    );
endinterface

// File: rtl/scope_wavegen_dac_tx.sv
// Phase-accumulator waveform generator feeding an 8-bit SPI DAC.
// One sample per 16-bit mode-0 frame, frames back to back while enabled.
module scope_wavegen_dac_tx #(
    parameter int CLK_DIV = 2,
    parameter int PHASE_W = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    scope_wavegen_dac_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    localparam logic [4:0] HALF_LAST = 5'(CLK_DIV - 1);
    localparam logic [4:0] GAP_LAST  = 5'(2 * CLK_DIV - 1);

    state_t               state;
    logic [PHASE_W-1:0]   phase;
    logic [14:0]          sr;
    logic [3:0]           bit_cnt;
    logic [4:0]           div_cnt;
    logic [7:0]           sample_q;
    logic                 done_q;
    logic                 cs_n_q;
    logic                 sclk_q;
    logic                 mosi_q;

    logic [7:0]           p;
    logic [7:0]           s;
    logic [15:0]          frame;

    assign p = phase[PHASE_W-1 -: 8];

    always_comb begin
        s = p;
        unique case (bus.shape)
            2'b00:   s = {8{p[7]}};
            2'b01:   s = p;
            2'b10:   s = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            default: s = bus.freq_step;
        endcase
    end

    // DAC control nibble: channel A, gain 1x, output active.
    assign frame = {4'b0011, s, 4'b0000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= '0;
            sr       <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            sample_q <= '0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    cs_n_q <= 1'b1;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    if (bus.ena) state <= LOAD;
                end
                LOAD: begin
                    sample_q <= s;
                    sr       <= frame[14:0];
                    mosi_q   <= frame[15];
                    cs_n_q   <= 1'b0;
                    sclk_q   <= 1'b0;
                    bit_cnt  <= 4'd15;
                    div_cnt  <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == HALF_LAST) begin
                        div_cnt <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_cnt == 4'd0) begin
                                state  <= GAP;
                                cs_n_q <= 1'b1;
                                mosi_q <= 1'b0;
                                done_q <= 1'b1;
                                if (bus.shape != 2'b11)
                                    phase <= phase + PHASE_W'(bus.freq_step);
                            end else begin
                                bit_cnt <= bit_cnt - 4'd1;
                                mosi_q  <= sr[14];
                                sr      <= {sr[13:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 5'd1;
                    end
                end
                GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt <= '0;
                        state   <= bus.ena ? LOAD : IDLE;
                    end else begin
                        div_cnt <= div_cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sample     = sample_q;
    assign bus.frame_done = done_q;
    assign bus.dac_cs_n   = cs_n_q;
    assign bus.dac_sclk   = sclk_q;
    assign bus.dac_mosi   = mosi_q;
endmodule

// File: tb/tb_scope_wavegen_dac_tx.sv
// Bench for scope_wavegen_dac_tx: CLK_DIV=2 and CLK_DIV=1 instances
// checked against a frame-level model of the DAC stream.
module tb_scope_wavegen_dac_tx;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    scope_wavegen_dac_tx_if ia ();
    scope_wavegen_dac_tx_if ib ();

    scope_wavegen_dac_tx #(.CLK_DIV(2), .PHASE_W(16)) dut_a (
        .clk(clk), .rst_n(rst_a), .bus(ia.slave)
    );
    scope_wavegen_dac_tx #(.CLK_DIV(1), .PHASE_W(16)) dut_b (
        .clk(clk), .rst_n(rst_b), .bus(ib.slave)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    // Sample value the DAC should receive for a given phase and shape.
    function automatic logic [7:0] model_sample(int unsigned ph, logic [1:0] sh,
                                                logic [7:0] fs);
        int unsigned idx;
        idx = (ph >> 8) & 255;
        case (sh)
            2'b00:   return (idx >= 128) ? 8'd255 : 8'd0;
            2'b01:   return 8'(idx);
            2'b10:   return (idx >= 128) ? 8'(255 - 2 * (idx - 128)) : 8'(2 * idx);
            default: return fs;
        endcase
    endfunction

    int unsigned mphase[2];
    int          frames[2], nbits[2], cslow[2], rises[2];
    int          last_rise[2], rise_gap[2], last_start[2], period[2];
    int          last_nbits[2], last_cslow[2];
    logic [7:0]  exp_s[2], last_sample[2];
    logic [15:0] word[2], last_word[2], first_word[2];
    logic        pcs[2], psc[2], pmo[2], infr[2], start_ok[2];

    logic       r_v, c_v, s_v, m_v, f_v;
    logic [7:0] sm_v, fs_v;
    logic [1:0] sh_v;
    int         dv;

    // Model and compare: every cycle, both instances.
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            r_v  = (d == 0) ? rst_a : rst_b;
            c_v  = (d == 0) ? ia.dac_cs_n : ib.dac_cs_n;
            s_v  = (d == 0) ? ia.dac_sclk : ib.dac_sclk;
            m_v  = (d == 0) ? ia.dac_mosi : ib.dac_mosi;
            f_v  = (d == 0) ? ia.frame_done : ib.frame_done;
            sm_v = (d == 0) ? ia.sample : ib.sample;
            fs_v = (d == 0) ? ia.freq_step : ib.freq_step;
            sh_v = (d == 0) ? ia.shape : ib.shape;
            dv   = (d == 0) ? 2 : 1;
            if (!r_v) begin
                chk("rst_cs_n", c_v, 1);
                chk("rst_sclk", s_v, 0);
                chk("rst_mosi", m_v, 0);
                chk("rst_sample", sm_v, 0);
                chk("rst_frame_done", f_v, 0);
                mphase[d] = 0; frames[d] = 0; infr[d] = 0; start_ok[d] = 0;
                pcs[d] = 1; psc[d] = 0; pmo[d] = 0; nbits[d] = 0;
            end else begin
                chk("frame_done_pulse", f_v, (!pcs[d] && c_v));
                if (c_v) begin
                    chk("idle_sclk", s_v, 0);
                    chk("idle_mosi", m_v, 0);
                end
                if (pcs[d] && !c_v) begin
                    exp_s[d] = model_sample(mphase[d], sh_v, fs_v);
                    chk("load_sample", sm_v, exp_s[d]);
                    word[d] = '0; nbits[d] = 0; cslow[d] = 0; infr[d] = 1;
                    if (start_ok[d]) period[d] = cyc - last_start[d];
                    last_start[d] = cyc; start_ok[d] = 1;
                end
                if (!c_v) begin
                    cslow[d]++;
                    if (!psc[d] && s_v) begin
                        chk("mosi_setup", m_v, pmo[d]);
                        word[d] = {word[d][14:0], m_v};
                        nbits[d]++;
                        rises[d]++;
                        if (nbits[d] > 1) rise_gap[d] = cyc - last_rise[d];
                        last_rise[d] = cyc;
                    end
                end
                if (!pcs[d] && c_v) begin
                    chk("frame_bits", nbits[d], 16);
                    chk("frame_word", word[d], {4'b0011, exp_s[d], 4'b0000});
                    chk("frame_sample", sm_v, exp_s[d]);
                    chk("cs_low_len", cslow[d], 32 * dv);
                    if (sh_v != 2'b11) mphase[d] = (mphase[d] + fs_v) & 32'hFFFF;
                    frames[d]++;
                    if (frames[d] == 1) first_word[d] = word[d];
                    last_word[d] = word[d]; last_sample[d] = sm_v;
                    last_nbits[d] = nbits[d]; last_cslow[d] = cslow[d];
                    infr[d] = 0;
                end
                pcs[d] = c_v; psc[d] = s_v; pmo[d] = m_v;
            end
        end
    end

    task automatic wait_frames(int d, int n, int budget);
        int k = 0;
        while (frames[d] < n && k < budget) begin
            @(negedge clk); #2; k++;
        end
        if (frames[d] < n) chk("timeout_frames", frames[d], n);
    endtask

    task automatic wait_bits(int d, int n, int budget);
        int k = 0;
        while (!(infr[d] && nbits[d] >= n) && k < budget) begin
            @(negedge clk); #2; k++;
        end
        if (!(infr[d] && nbits[d] >= n)) chk("timeout_bits", nbits[d], n);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    logic [7:0] saw_exp [5];
    int f0, r0;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        ia.ena = 1'b0; ia.shape = 2'b11; ia.freq_step = 8'hA5;
        ib.ena = 1'b0; ib.shape = 2'b10; ib.freq_step = 8'h40;
        saw_exp[0] = 8'h00; saw_exp[1] = 8'h00; saw_exp[2] = 8'h01;
        saw_exp[3] = 8'h01; saw_exp[4] = 8'h02;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_cs_n", ia.dac_cs_n, 1);
        chk("reset_sclk", ia.dac_sclk, 0);
        chk("reset_mosi", ia.dac_mosi, 0);
        chk("reset_sample", ia.sample, 0);
        chk("reset_frame_done", ia.frame_done, 0);

        // DC level frames
        ia.ena = 1'b1;
        rst_a = 1'b1;
        wait_frames(0, 3, 400);
        chk("dc_word", first_word[0], 16'h3A50);
        chk("dc_sample", last_sample[0], 8'hA5);
        chk("dc_cs_low", last_cslow[0], 64);
        chk("dc_period", period[0], 69);

        // Sawtooth from phase 0 (DC held the phase)
        ia.shape = 2'b01; ia.freq_step = 8'h80;
        for (int i = 0; i < 5; i++) begin
            wait_frames(0, 4 + i, 200);
            chk("saw_sample", last_sample[0], saw_exp[i]);
        end

        // ena dropped mid-frame: frame finishes, then idle
        wait_bits(0, 10, 200);
        ia.ena = 1'b0;
        f0 = frames[0];
        wait_frames(0, f0 + 1, 200);
        chk("drop_bits", last_nbits[0], 16);
        r0 = rises[0];
        repeat (200) @(negedge clk);
        #2;
        chk("drop_no_sclk", rises[0], r0);
        chk("drop_no_frame", frames[0], f0 + 1);
        chk("drop_cs_high", ia.dac_cs_n, 1);
        ia.ena = 1'b1;
        wait_frames(0, f0 + 2, 400);
        chk("resume_sample", last_sample[0], 8'h03);

        // Asynchronous reset mid-SHIFT
        wait_bits(0, 5, 200);
        @(posedge clk);
        #3;
        rst_a = 1'b0;
        #1;
        chk("async_cs_n", ia.dac_cs_n, 1);
        chk("async_sclk", ia.dac_sclk, 0);
        @(negedge clk);
        #2;
        rst_a = 1'b1;
        wait_frames(0, 1, 200);
        chk("post_rst_sample", last_sample[0], 8'h00);
        chk("post_rst_word", last_word[0], 16'h3000);

        // Triangle on the CLK_DIV=1 instance
        ib.ena = 1'b1;
        rst_b = 1'b1;
        wait_frames(1, 257, 257 * 35 + 100);
        chk("tri_4000", last_sample[1], 8'h80);
        chk("div1_period", period[1], 35);
        chk("div1_sclk_period", rise_gap[1], 2);
        wait_frames(1, 769, 512 * 35 + 100);
        chk("tri_C000", last_sample[1], 8'h7F);
        wait_frames(1, 1025, 256 * 35 + 100);
        chk("tri_wrap", last_sample[1], 8'h00);

        // Square from phase 0
        ib.ena = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        ib.shape = 2'b00; ib.freq_step = 8'hFF; ib.ena = 1'b1;
        rst_b = 1'b1;
        wait_frames(1, 129, 129 * 35 + 100);
        chk("square_before", last_sample[1], 8'h00);
        wait_frames(1, 130, 100);
        chk("square_after", last_sample[1], 8'hFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
